// File: rtl/riscv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_pkg
// Types and constants shared by the pipeline forwarding/hazard logic.
//   fwd_sel_t  : 2-bit operand-mux select driven into the EX stage.
//   dst_tag_t  : destination tag for an in-flight instruction, kept by the
//                forwarding unit for the instructions in EX and MEM.
//   REG_ADDR_W : register index width.
// -----------------------------------------------------------------------------
package riscv_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM_WB  = 2'b01,
    FWD_EX_MEM  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } dst_tag_t;

  // An empty pipeline slot: all fields zero.
  localparam dst_tag_t BUBBLE_TAG = '0;

endpackage

// File: rtl/forward_ctrl_unit_if.sv
// -----------------------------------------------------------------------------
// forward_ctrl_unit_if
// Bundles the ID-stage instruction fields, the EX flush, and the forwarding
// unit's results.
//   master : ID/EX side of the pipeline (drives ID fields and ex_flush).
//   slave  : forwarding unit (drives selects, stall and event counters).
// -----------------------------------------------------------------------------
interface forward_ctrl_unit_if #(
  parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) ();

  logic                   id_valid;
  logic [REG_ADDR_W-1:0]  id_rs1;
  logic [REG_ADDR_W-1:0]  id_rs2;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic [REG_ADDR_W-1:0]  id_rd;
  logic                   id_reg_write;
  logic                   id_mem_read;
  logic                   ex_flush;

  riscv_pipe_pkg::fwd_sel_t forward_a;
  riscv_pipe_pkg::fwd_sel_t forward_b;
  logic                   stall;
  logic [CNT_W-1:0]       stall_count;
  logic [CNT_W-1:0]       fwd_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, ex_flush,
    input  forward_a, forward_b, stall, stall_count, fwd_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, ex_flush,
    output forward_a, forward_b, stall, stall_count, fwd_count
  );

endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that adds 0, 1 or 2 per clock and sticks at all-ones.
//   clk     : clock
//   rst     : asynchronous active-high reset, clears the count
//   inc_i   : increment amount for this cycle (0..2)
//   count_o : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   sum;

  // One extra bit catches the carry out; any carry means the true sum is
  // beyond all-ones, so clamp.
  always_comb begin
    sum     = {1'b0, count_q} + (W + 1)'(inc_i);
    count_d = sum[W] ? '1 : sum[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/forward_ctrl_unit.sv
// -----------------------------------------------------------------------------
// forward_ctrl_unit
// Computes the EX-stage operand forwarding selects while the consumer is in
// ID, registers them so they are valid in its EX cycle, and raises the
// load-use stall. Keeps shadow destination tags for the EX and MEM stages.
//   clk : pipeline clock
//   rst : asynchronous active-high reset
//   bus : slave side of forward_ctrl_unit_if
//         in : id_valid, id_rs1/2, id_uses_rs1/2, id_rd, id_reg_write,
//              id_mem_read, ex_flush
//         out: forward_a/b (registered), stall (combinational),
//              stall_count, fwd_count (saturating)
// -----------------------------------------------------------------------------
module forward_ctrl_unit #(
  parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  forward_ctrl_unit_if.slave  bus
);

  import riscv_pipe_pkg::*;

  dst_tag_t ex_tag_q, ex_tag_d;
  dst_tag_t mem_tag_q;

  fwd_sel_t sel_q [2];
  fwd_sel_t sel_d [2];

  logic [REG_ADDR_W-1:0] src_reg [2];
  logic                  src_used [2];

  logic stall_c;
  logic bubble_c;

  logic [1:0]       cnt_inc [2];
  logic [CNT_W-1:0] cnt_val [2];

  function automatic logic tag_hit(input dst_tag_t t, input logic [REG_ADDR_W-1:0] r);
    return t.valid && t.reg_write && (t.rd != '0) && (t.rd == r);
  endfunction

  always_comb begin
    src_reg[0]  = bus.id_rs1;
    src_reg[1]  = bus.id_rs2;
    src_used[0] = bus.id_uses_rs1;
    src_used[1] = bus.id_uses_rs2;
  end

  // Load in EX whose result a source in ID needs: one bubble lets the load
  // reach MEM, after which the MEM/WB path covers it. Flush wins.
  always_comb begin
    stall_c = bus.id_valid && !bus.ex_flush &&
              ex_tag_q.valid && ex_tag_q.mem_read && (ex_tag_q.rd != '0) &&
              ((bus.id_uses_rs1 && (ex_tag_q.rd == bus.id_rs1)) ||
               (bus.id_uses_rs2 && (ex_tag_q.rd == bus.id_rs2)));
    bubble_c = bus.ex_flush || stall_c || !bus.id_valid;
  end

  always_comb begin
    ex_tag_d = BUBBLE_TAG;
    if (!bubble_c) begin
      ex_tag_d.valid     = 1'b1;
      ex_tag_d.rd        = bus.id_rd;
      ex_tag_d.reg_write = bus.id_reg_write;
      ex_tag_d.mem_read  = bus.id_mem_read;
    end
  end

  // Per-operand select; EX/MEM checked first so the youngest producer wins.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sel
    always_comb begin
      sel_d[gi] = FWD_REGFILE;
      if (!bubble_c && src_used[gi]) begin
        if (tag_hit(ex_tag_q, src_reg[gi])) begin
          sel_d[gi] = FWD_EX_MEM;
        end else if (tag_hit(mem_tag_q, src_reg[gi])) begin
          sel_d[gi] = FWD_MEM_WB;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_tag_q  <= BUBBLE_TAG;
      mem_tag_q <= BUBBLE_TAG;
      sel_q[0]  <= FWD_REGFILE;
      sel_q[1]  <= FWD_REGFILE;
    end else begin
      ex_tag_q  <= ex_tag_d;
      mem_tag_q <= ex_tag_q;
      sel_q[0]  <= sel_d[0];
      sel_q[1]  <= sel_d[1];
    end
  end

  // Counter 0: stall cycles. Counter 1: non-zero selects being loaded.
  always_comb begin
    cnt_inc[0] = {1'b0, stall_c};
    cnt_inc[1] = {1'b0, (sel_d[0] != FWD_REGFILE)} +
                 {1'b0, (sel_d[1] != FWD_REGFILE)};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (cnt_inc[gi]),
      .count_o (cnt_val[gi])
    );
  end

  assign bus.forward_a   = sel_q[0];
  assign bus.forward_b   = sel_q[1];
  assign bus.stall       = stall_c;
  assign bus.stall_count = cnt_val[0];
  assign bus.fwd_count   = cnt_val[1];

endmodule

// File: doc/forward_ctrl_unit.md
Name: forward_ctrl_unit

Overview:
- Generates the 2-bit forwarding selects consumed by the EX-stage operand muxes, plus the load-use stall.
- Sits at the ID/EX boundary and keeps its own shadow pipeline of destination tags for the instructions in EX and MEM.
- Selects are computed while an instruction is in ID and registered, so they are valid during that instruction's EX cycle.
- Also keeps saturating stall and forward event counters.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_ADDR_W  ID source register 1.
- id_rs2  in  REG_ADDR_W  ID source register 2.
- id_uses_rs1  in  1  instruction reads rs1.
- id_uses_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_ADDR_W  ID destination register.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- ex_flush  in  1  taken branch/jump resolved in EX; squash IF and ID.
- forward_a  out  2  registered select for ALU operand A.
- forward_b  out  2  registered select for ALU operand B.
- stall  out  1  combinational; hold PC and IF/ID, bubble ID/EX.
- stall_count  out  CNT_W  saturating count of stall cycles.
- fwd_count  out  CNT_W  saturating count of issued non-zero selects.

Behaviour:
- Select encoding:
  - 00 = register file.
  - 01 = MEM/WB.
  - 10 = EX/MEM.
  - 11 is never driven.
- Shadow tags: ex_tag and mem_tag, each holding {valid, rd, reg_write, mem_read}. Every clock:
  - mem_tag <= ex_tag.
  - ex_tag <= bubble if ex_flush or stall or !id_valid; otherwise ex_tag <= ID fields.
  - A bubble has all fields 0.
- Hit rules:
  - hit_ex(r): ex_tag.valid && ex_tag.reg_write && ex_tag.rd != 0 && ex_tag.rd == r.
  - hit_mem(r): the same test against mem_tag.
  - x0 never forwards.
- forward_a next value: 10 if id_uses_rs1 && hit_ex(rs1); else 01 if id_uses_rs1 && hit_mem(rs1); else 00. This gives the EX/MEM priority rule, the most recent producer wins.
- forward_b next value: the same rule using rs2 and id_uses_rs2.
- forward_a/forward_b load 00 when ex_flush, stall, or !id_valid.
- Latency: selects appear exactly one cycle after the consumer is in ID.
- Write-back to read in the same cycle is handled by the register file (write-first), so there is no WB tag.
- Load-use stall:
  - stall = id_valid && !ex_flush && ex_tag.mem_read && ex_tag.valid && ex_tag.rd != 0 && ((id_uses_rs1 && ex_tag.rd == id_rs1) || (id_uses_rs2 && ex_tag.rd == id_rs2)).
  - A stall is exactly one cycle: next cycle the load is in mem_tag and the consumer gets select 01.
- ex_flush has priority over stall; a flush during a stall clears the stall in the same cycle.
- Counters:
  - stall_count increments on each cycle stall=1.
  - fwd_count increments once per registered select update where forward_a != 00, and once more where forward_b != 00 (+0, +1 or +2 per cycle).
  - Both saturate at all-ones and never wrap.
- Reset, asynchronous:
  - All tags cleared.
  - forward_a = forward_b = 00.
  - Counters = 0.
  - stall = 0, since the tags are invalid.
  - Reset mid-stall drops the stall immediately.

Decomposition:
- Shared package (riscv_pipe_pkg): fwd_sel_t enum with FWD_REGFILE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10; dst_tag_t struct {valid, rd, reg_write, mem_read}; REG_ADDR_W constant.
- One natural sub-module: sat_counter (width parameter, increment amount 0..2, saturating), instantiated twice.

Test Plan:
- EX/MEM forward: `add x5,x1,x2` then `sub x6,x5,x3` -> in sub's EX cycle forward_a=10, forward_b=00, fwd_count=1.
- MEM/WB forward and priority:
  - `add x5`, `nop`, `or x7,x1,x5` -> forward_b=01.
  - `add x5`, `add x5`, `and x8,x5,x5` -> forward_a=forward_b=10.
- Load-use: `lw x4,0(x1)` then `add x9,x4,x2` -> stall=1 for exactly one cycle and stall_count=1; add's EX selects are forward_a=01.
- x0 and unused operands: writes to x0 never forward; an `lw x4` followed by `lui x4,...` (uses no rs) -> no stall, selects 00.
- Flush: ex_flush asserted in the same cycle as a load-use condition -> stall=0, next ex_tag is a bubble, next selects 00.
- Reset and saturation:
  - With CNT_W=2, 5 stall cycles -> stall_count holds at 3.
  - Asserting rst asynchronously mid-stall -> stall=0 and all outputs zero before the next clock edge.
